// File: rtl/fifo_pkg.sv
// Shared widths, pointer type and read-mode selectors
// for the single-clock FIFO.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/sdpram_sc.sv
// Single-clock simple dual-port RAM with registered read.
// Only the output register is reset; the array is not.
module sdpram_sc #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, count, flags,
// sticky errors and optional first-word-fall-through.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FWFT       = MODE_STD,
  parameter int AF_THRESH  = (2**ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  typedef logic [ADDR_WIDTH:0] cnt_t;

  localparam cnt_t DEPTH   = cnt_t'(2**ADDR_WIDTH);
  localparam cnt_t AF      = cnt_t'(AF_THRESH);
  localparam cnt_t AE      = cnt_t'(AE_THRESH);
  localparam bit   IS_FWFT = (FWFT == MODE_FWFT);

  cnt_t wr_ptr, rd_ptr;
  cnt_t wr_ptr_n, rd_ptr_n, cnt_n;
  logic hv, hv_n;
  logic wr_acc, pop, re;
  logic rv_n, empty_n;

  // In FWFT mode rd_ptr is the fetch pointer into the RAM and
  // the RAM output register is the head word when hv is set.
  always_comb begin
    wr_acc   = wr_en && !full && !clr;
    pop      = rd_en && !empty && !clr;
    re       = 1'b0;
    hv_n     = 1'b0;
    rv_n     = 1'b0;
    wr_ptr_n = wr_ptr + cnt_t'(wr_acc);
    if (IS_FWFT) begin
      re   = (wr_ptr != rd_ptr) && (!hv || pop) && !clr;
      hv_n = re || (hv && !pop);
      rv_n = hv_n;
    end else begin
      re   = pop;
      rv_n = pop;
    end
    rd_ptr_n = rd_ptr + cnt_t'(re);
    cnt_n    = wr_ptr_n - rd_ptr_n + cnt_t'(hv_n);
    if (clr) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      cnt_n    = '0;
    end
    empty_n = IS_FWFT ? !hv_n : (cnt_n == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      hv           <= 1'b0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      hv           <= hv_n;
      count        <= cnt_n;
      full         <= (cnt_n == DEPTH);
      almost_full  <= (cnt_n >= AF);
      empty        <= empty_n;
      almost_empty <= (cnt_n <= AE);
      rd_valid     <= rv_n;
      overflow     <= !clr && (overflow || (wr_en && full));
      underflow    <= !clr && (underflow || (rd_en && empty));
    end
  end

  sdpram_sc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .we   (wr_acc),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata(wr_data),
    .re   (re),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: standard-mode vector table with
// a read-data scoreboard, plus FWFT and async-reset sequences.
module tb_sync_fifo_ctrl;
  import fifo_pkg::*;

  typedef struct {
    logic       clr;
    logic       wr;
    logic       rd;
    logic [7:0] d;
    int         ecnt;
    logic       eovf;
    logic       eunf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, clr;
  logic       wr_en, rd_en;
  logic [7:0] wr_data;
  logic       s_full, s_af, s_rv, s_empty, s_ae, s_ovf, s_unf;
  logic [7:0] s_rd;
  logic [4:0] s_cnt;

  logic       f_wr_en, f_rd_en;
  logic [7:0] f_wr_data;
  logic       f_full, f_af, f_rv, f_empty, f_ae, f_ovf, f_unf;
  logic [7:0] f_rd;
  logic [4:0] f_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic [7:0] sb[$];
  vec_t       tbl[$];

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(MODE_STD)
  ) u_std (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data),
    .full(s_full), .almost_full(s_af),
    .rd_en(rd_en), .rd_data(s_rd), .rd_valid(s_rv),
    .empty(s_empty), .almost_empty(s_ae),
    .count(s_cnt), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_ctrl #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(MODE_FWFT)
  ) u_fw (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(f_wr_en), .wr_data(f_wr_data),
    .full(f_full), .almost_full(f_af),
    .rd_en(f_rd_en), .rd_data(f_rd), .rd_valid(f_rv),
    .empty(f_empty), .almost_empty(f_ae),
    .count(f_cnt), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic c, logic w, logic r,
                              logic [7:0] d, int n,
                              logic o, logic u);
    vec_t v;
    v.clr = c; v.wr = w; v.rd = r; v.d = d;
    v.ecnt = n; v.eovf = o; v.eunf = u;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic racc;
    logic full0;
    racc  = 1'b0;
    full0 = (mq.size() == 16);
    clr     = v.clr;
    wr_en   = v.wr;
    rd_en   = v.rd;
    wr_data = v.d;
    if (v.clr) begin
      mq.delete();
    end else begin
      if (v.rd && mq.size() != 0) begin
        racc = 1'b1;
        sb.push_back(mq.pop_front());
      end
      if (v.wr && !full0) mq.push_back(v.d);
    end
    step();
    chk("rd_valid", 32'(s_rv), 32'(racc));
    if (s_rv) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: rd_valid=1, got 0x%0h, expected no word",
                 s_rd);
      end else begin
        chk("rd_data", 32'(s_rd), 32'(sb.pop_front()));
      end
    end
    chk("count", 32'(s_cnt), 32'(v.ecnt));
    chk("full", 32'(s_full), 32'(v.ecnt == 16));
    chk("empty", 32'(s_empty), 32'(v.ecnt == 0));
    chk("almost_full", 32'(s_af), 32'(v.ecnt >= 14));
    chk("almost_empty", 32'(s_ae), 32'(v.ecnt <= 2));
    chk("overflow", 32'(s_ovf), 32'(v.eovf));
    chk("underflow", 32'(s_unf), 32'(v.eunf));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;

    // test 1: fill; test 2: drain
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0, 1, 0, 8'(i), i + 1, 0, 0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0, 0, 1, 8'h00, 15 - i, 0, 0));
    // test 3: wrap across the pointer MSB
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 1, 0, 8'(8'h10 + i), i + 1, 0, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 0, 1, 8'h00, 9 - i, 0, 0));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(0, 1, 0, 8'(8'hA0 + i), i + 1, 0, 0));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(0, 0, 1, 8'h00, 11 - i, 0, 0));
    // test 4: both-high at full and at empty, then clr
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0, 1, 0, 8'(8'hC0 + i), i + 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'hEE, 15, 1, 0));
    for (int i = 0; i < 15; i++)
      tbl.push_back(mk(0, 0, 1, 8'h00, 14 - i, 1, 0));
    tbl.push_back(mk(0, 1, 1, 8'h77, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1));
    tbl.push_back(mk(1, 1, 1, 8'h99, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst count", 32'(s_cnt), 0);
    chk("rst empty", 32'(s_empty), 1);
    chk("rst full", 32'(s_full), 0);
    chk("rst almost_full", 32'(s_af), 0);
    chk("rst almost_empty", 32'(s_ae), 1);
    chk("rst rd_valid", 32'(s_rv), 0);
    chk("rst rd_data", 32'(s_rd), 0);
    chk("rst overflow", 32'(s_ovf), 0);
    chk("rst underflow", 32'(s_unf), 0);
    chk("rst f_empty", 32'(f_empty), 1);
    chk("rst f_rd_valid", 32'(f_rv), 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    chk("clr rd_data", 32'(s_rd), 0);
    chk("scoreboard drained", 32'(sb.size()), 0);

    // test 5: FWFT head latency and pop
    f_wr_en = 1'b1;
    f_wr_data = 8'h5A;
    step();
    chk("fwft empty after N", 32'(f_empty), 1);
    chk("fwft count after N", 32'(f_cnt), 1);
    f_wr_data = 8'h5B;
    step();
    chk("fwft empty after N+1", 32'(f_empty), 0);
    chk("fwft rd_valid head", 32'(f_rv), 1);
    chk("fwft head 5A", 32'(f_rd), 32'h5A);
    chk("fwft count 2", 32'(f_cnt), 2);
    f_wr_en = 1'b0;
    f_rd_en = 1'b1;
    step();
    chk("fwft head 5B", 32'(f_rd), 32'h5B);
    chk("fwft empty with 5B", 32'(f_empty), 0);
    chk("fwft count 1", 32'(f_cnt), 1);
    step();
    chk("fwft empty drained", 32'(f_empty), 1);
    chk("fwft rd_valid drained", 32'(f_rv), 0);
    chk("fwft count 0", 32'(f_cnt), 0);
    chk("fwft underflow clear", 32'(f_unf), 0);
    step();
    chk("fwft underflow set", 32'(f_unf), 1);
    chk("fwft overflow clear", 32'(f_ovf), 0);
    chk("fwft almost_empty", 32'(f_ae), 1);
    chk("fwft almost_full", 32'(f_af), 0);
    chk("fwft full", 32'(f_full), 0);
    f_rd_en = 1'b0;

    // test 6: async reset with count=7 and a read in flight
    for (int i = 0; i < 8; i++)
      apply(mk(0, 1, 0, 8'(8'h30 + i), i + 1, 0, 0));
    apply(mk(0, 0, 1, 8'h00, 7, 0, 0));
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async count", 32'(s_cnt), 0);
    chk("async empty", 32'(s_empty), 1);
    chk("async rd_valid", 32'(s_rv), 0);
    chk("async rd_data", 32'(s_rd), 0);
    chk("async f_underflow", 32'(f_unf), 0);
    rst = 1'b0;
    mq.delete();
    sb.delete();
    apply(mk(0, 1, 0, 8'h3C, 1, 0, 0));
    apply(mk(0, 0, 1, 8'h00, 0, 0, 0));
    chk("post-reset word", 32'(s_rd), 32'h3C);
    rd_en = 1'b0;
    step();
    chk("rd_data holds", 32'(s_rd), 32'h3C);
    chk("rd_valid one cycle", 32'(s_rv), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
